instr_encoder: RTL and testbench

//  Encoder for the single-cycle CPU's instruction set (R, ADDI, LW, SW, SLTI, BEQ).

---
 rtl/instr_encoder.sv | 120 ++++++++++++
 tb/tb_instr_encoder.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_encoder.sv
// Instruction encoder: turns R/I-type field requests into MIPS words and
// streams them into instruction memory at consecutive word addresses.
module instr_encoder #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          DEPTH     = 32,
    localparam int         CW        = $clog2(DEPTH + 1)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          clear_i,
    input  logic          req_valid_i,
    output logic          req_ready_o,
    input  logic [2:0]    req_kind_i,
    input  logic [4:0]    rs_i,
    input  logic [4:0]    rt_i,
    input  logic [4:0]    rd_i,
    input  logic [5:0]    funct_i,
    input  logic [15:0]   imm_i,
    output logic          imem_we_o,
    output logic [31:0]   imem_addr_o,
    output logic [31:0]   imem_data_o,
    output logic [CW-1:0] count_o,
    output logic          full_o,
    output logic          err_o
);

    typedef enum logic [1:0] {
        IDLE,
        ENC,
        WR
    } state_t;

    state_t      state;
    logic [2:0]  kind_q;
    logic [4:0]  rs_q;
    logic [4:0]  rt_q;
    logic [4:0]  rd_q;
    logic [5:0]  funct_q;
    logic [15:0] imm_q;
    logic [31:0] word;
    logic        legal;
    logic        accept;

    assign full_o      = (count_o == CW'(DEPTH));
    assign req_ready_o = (state == IDLE) && !full_o;
    assign accept      = req_valid_i && req_ready_o && !clear_i;

    always_comb begin
        legal = 1'b1;
        word  = '0;
        case (kind_q)
            3'd0: word = {6'h00, rs_q, rt_q, rd_q, 5'b0, funct_q};
            3'd1: word = {6'h08, rs_q, rt_q, imm_q};
            3'd2: word = {6'h23, rs_q, rt_q, imm_q};
            3'd3: word = {6'h2B, rs_q, rt_q, imm_q};
            3'd4: word = {6'h0A, rs_q, rt_q, imm_q};
            3'd5: word = {6'h04, rs_q, rt_q, imm_q};
            default: legal = 1'b0;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state       <= IDLE;
            kind_q      <= '0;
            rs_q        <= '0;
            rt_q        <= '0;
            rd_q        <= '0;
            funct_q     <= '0;
            imm_q       <= '0;
            imem_we_o   <= 1'b0;
            imem_addr_o <= '0;
            imem_data_o <= '0;
            count_o     <= '0;
            err_o       <= 1'b0;
        end else if (clear_i) begin
            state     <= IDLE;
            imem_we_o <= 1'b0;
            count_o   <= '0;
            err_o     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    imem_we_o <= 1'b0;
                    if (accept) begin
                        kind_q  <= req_kind_i;
                        rs_q    <= rs_i;
                        rt_q    <= rt_i;
                        rd_q    <= rd_i;
                        funct_q <= funct_i;
                        imm_q   <= imm_i;
                        state   <= ENC;
                    end
                end
                ENC: begin
                    // address uses the count before this word is counted
                    if (legal) begin
                        imem_data_o <= word;
                        imem_addr_o <= BASE_ADDR + (32'(count_o) << 2);
                        imem_we_o   <= 1'b1;
                        state       <= WR;
                    end else begin
                        err_o <= 1'b1;
                        state <= IDLE;
                    end
                end
                WR: begin
                    imem_we_o <= 1'b0;
                    count_o   <= count_o + CW'(1);
                    state     <= IDLE;
                end
                default: begin
                    imem_we_o <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder: vector table plus write scoreboard and
// hand-written corner sequences (illegal kind, full, clear, reset).
module tb_instr_encoder;

    localparam int          DEPTH = 4;
    localparam int          CW    = $clog2(DEPTH + 1);
    localparam logic [31:0] BASE  = 32'h0000_0000;

    logic          clk = 1'b0;
    logic          rst_i = 1'b0;
    logic          clear_i = 1'b0;
    logic          req_valid_i = 1'b0;
    logic          req_ready_o;
    logic [2:0]    req_kind_i = '0;
    logic [4:0]    rs_i = '0;
    logic [4:0]    rt_i = '0;
    logic [4:0]    rd_i = '0;
    logic [5:0]    funct_i = '0;
    logic [15:0]   imm_i = '0;
    logic          imem_we_o;
    logic [31:0]   imem_addr_o;
    logic [31:0]   imem_data_o;
    logic [CW-1:0] count_o;
    logic          full_o;
    logic          err_o;

    instr_encoder #(.BASE_ADDR(BASE), .DEPTH(DEPTH)) dut (
        .clk_i      (clk),
        .rst_i      (rst_i),
        .clear_i    (clear_i),
        .req_valid_i(req_valid_i),
        .req_ready_o(req_ready_o),
        .req_kind_i (req_kind_i),
        .rs_i       (rs_i),
        .rt_i       (rt_i),
        .rd_i       (rd_i),
        .funct_i    (funct_i),
        .imm_i      (imm_i),
        .imem_we_o  (imem_we_o),
        .imem_addr_o(imem_addr_o),
        .imem_data_o(imem_data_o),
        .count_o    (count_o),
        .full_o     (full_o),
        .err_o      (err_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  kind;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [5:0]  funct;
        logic [15:0] imm;
        logic        clr;
        logic [31:0] data;
    } vec_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } exp_t;

    vec_t vecs[6];
    exp_t sb_q[$];
    exp_t e;
    int   checks = 0;
    int   errors = 0;
    int   model_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (imem_we_o === 1'b1) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got addr %h data %h expected none",
                         imem_addr_o, imem_data_o);
            end else begin
                e = sb_q.pop_front();
                chk("wr_addr", imem_addr_o, e.addr);
                chk("wr_data", imem_data_o, e.data);
            end
        end
    end

    task automatic send(input logic [2:0] kind, input logic [4:0] rs,
                        input logic [4:0] rt, input logic [4:0] rd,
                        input logic [5:0] funct, input logic [15:0] imm,
                        input logic [31:0] data, input bit push);
        int n = 0;
        @(negedge clk);
        req_kind_i  = kind;
        rs_i        = rs;
        rt_i        = rt;
        rd_i        = rd;
        funct_i     = funct;
        imm_i       = imm;
        req_valid_i = 1'b1;
        while (!req_ready_o && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready_o) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: ready got 0 expected 1");
            req_valid_i = 1'b0;
            return;
        end
        if (push) begin
            sb_q.push_back('{BASE + 32'(model_cnt * 4), data});
            model_cnt++;
        end
        @(posedge clk);
        #1;
        req_valid_i = 1'b0;
    endtask

    task automatic send_vec(input int i);
        send(vecs[i].kind, vecs[i].rs, vecs[i].rt, vecs[i].rd,
             vecs[i].funct, vecs[i].imm, vecs[i].data, 1'b1);
    endtask

    task automatic do_clear();
        @(negedge clk);
        clear_i = 1'b1;
        @(negedge clk);
        clear_i = 1'b0;
        model_cnt = 0;
    endtask

    initial begin
        vecs[0] = '{3'd1, 5'd0, 5'd1, 5'd0, 6'h00, 16'h0005, 1'b0, 32'h20010005};
        vecs[1] = '{3'd2, 5'd1, 5'd2, 5'd0, 6'h00, 16'h0004, 1'b1, 32'h8C220004};
        vecs[2] = '{3'd3, 5'd1, 5'd2, 5'd0, 6'h00, 16'h0008, 1'b0, 32'hAC220008};
        vecs[3] = '{3'd5, 5'd1, 5'd2, 5'd0, 6'h00, 16'hFFFF, 1'b0, 32'h1022FFFF};
        vecs[4] = '{3'd0, 5'd1, 5'd2, 5'd3, 6'h20, 16'h0000, 1'b1, 32'h00221820};
        vecs[5] = '{3'd4, 5'd1, 5'd4, 5'd0, 6'h00, 16'h000A, 1'b0, 32'h2824000A};

        repeat (3) @(negedge clk);
        chk("rst_we", 32'(imem_we_o), 0);
        chk("rst_addr", imem_addr_o, 0);
        chk("rst_data", imem_data_o, 0);
        chk("rst_count", 32'(count_o), 0);
        chk("rst_full", 32'(full_o), 0);
        chk("rst_err", 32'(err_o), 0);
        rst_i = 1'b1;
        @(negedge clk);
        chk("ready_after_reset", 32'(req_ready_o), 1);

        // single addi: latency and count
        send_vec(0);
        @(negedge clk);
        chk("enc_ready", 32'(req_ready_o), 0);
        chk("enc_we", 32'(imem_we_o), 0);
        @(negedge clk);
        chk("wr_we", 32'(imem_we_o), 1);
        chk("wr_count_pre", 32'(count_o), 0);
        @(negedge clk);
        chk("count_post", 32'(count_o), 1);
        chk("ready_back", 32'(req_ready_o), 1);
        chk("we_after", 32'(imem_we_o), 0);

        for (int i = 1; i < 6; i++) begin
            if (vecs[i].clr) begin
                repeat (3) @(negedge clk);
                do_clear();
            end
            send_vec(i);
            @(negedge clk);
            chk("ready_between", 32'(req_ready_o), 0);
        end
        repeat (3) @(negedge clk);
        chk("count_tbl", 32'(count_o), 2);

        // illegal kind sets sticky error, no write
        send(3'd7, 5'd1, 5'd1, 5'd1, 6'h3F, 16'hAAAA, 32'h0, 1'b0);
        repeat (3) @(negedge clk);
        chk("err_set", 32'(err_o), 1);
        chk("count_illegal", 32'(count_o), 2);
        send(3'd1, 5'd0, 5'd5, 5'd0, 6'h00, 16'h1234, 32'h20051234, 1'b1);
        repeat (3) @(negedge clk);
        chk("err_sticky", 32'(err_o), 1);
        chk("count_3", 32'(count_o), 3);
        send(3'd3, 5'd3, 5'd4, 5'd0, 6'h00, 16'h0010, 32'hAC640010, 1'b1);
        repeat (3) @(negedge clk);
        chk("count_full", 32'(count_o), 4);
        chk("full_set", 32'(full_o), 1);
        chk("ready_full", 32'(req_ready_o), 0);

        // held valid while full must not be taken
        @(negedge clk);
        req_kind_i  = 3'd1;
        req_valid_i = 1'b1;
        repeat (5) @(negedge clk);
        chk("count_stall", 32'(count_o), 4);
        chk("ready_stall", 32'(req_ready_o), 0);
        req_valid_i = 1'b0;

        do_clear();
        chk("clr_count", 32'(count_o), 0);
        chk("clr_err", 32'(err_o), 0);
        chk("clr_full", 32'(full_o), 0);
        chk("clr_ready", 32'(req_ready_o), 1);

        // clear wins over a request presented with it
        @(negedge clk);
        clear_i     = 1'b1;
        req_kind_i  = 3'd1;
        req_valid_i = 1'b1;
        @(negedge clk);
        clear_i     = 1'b0;
        req_valid_i = 1'b0;
        chk("clr_no_accept", 32'(req_ready_o), 1);
        repeat (3) @(negedge clk);
        chk("clr_no_write", 32'(count_o), 0);
        send(3'd1, 5'd2, 5'd3, 5'd0, 6'h00, 16'h00FF, 32'h204300FF, 1'b1);
        repeat (3) @(negedge clk);
        chk("count_after_clr", 32'(count_o), 1);

        // reset while in ENC drops the request
        send(3'd2, 5'd1, 5'd2, 5'd0, 6'h00, 16'h0004, 32'h8C220004, 1'b1);
        rst_i = 1'b0;
        void'(sb_q.pop_back());
        model_cnt = 0;
        @(negedge clk);
        chk("rst2_we", 32'(imem_we_o), 0);
        chk("rst2_addr", imem_addr_o, 0);
        chk("rst2_data", imem_data_o, 0);
        chk("rst2_count", 32'(count_o), 0);
        repeat (2) @(negedge clk);
        rst_i = 1'b1;
        send(3'd2, 5'd1, 5'd2, 5'd0, 6'h00, 16'h0004, 32'h8C220004, 1'b1);
        repeat (3) @(negedge clk);
        chk("count_after_rst", 32'(count_o), 1);

        chk("sb_empty", 32'(sb_q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
